roc_decoder: RTL

- AER receiver at the far end of the 10-bit rank-order-coded link; pairs with the ROC encoder.
- Completes a 4-phase REQ/ACK handshake per event.
- Arms on the encoder's reset-code preamble (0x1FF sent twice).
- Assigns each received pixel index its arrival rank and exposes winner, count, rank table and error flags to the inference/readout logic.

---
 rtl/roc_pkg.sv | 15 +
 rtl/roc_decoder_aer_rx_handshake.sv | 90 +++++++++
 rtl/roc_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/roc_pkg.sv
// Shared constants for the rank-order-coded AER link. The encoder imports the
// same package so both ends agree on the preamble code and repeat count.
package roc_pkg;

  localparam int                   AER_WIDTH    = 10;
  localparam logic [AER_WIDTH-1:0] RESET_CODE   = 10'h1FF;
  localparam int                   RESET_REPEAT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UPDATE  = 2'd1,
    WAIT_LO = 2'd2
  } dec_state_e;

endpackage

// File: rtl/roc_decoder_aer_rx_handshake.sv
// 4-phase AER receive handshake. Latches the event address, raises the
// acknowledge and presents a one-cycle evt_valid/evt_addr pulse to the rank
// logic.
// Build option: ROC_DECODER_REQ_SYNC_EN inserts a 2-flop synchroniser on the
// request so the transmitter may sit in another clock domain.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for request; ack low
// UPDATE  | one cycle: latched address is handed to the rank logic
// WAIT_LO | ack high, waiting for the request to return low
module aer_rx_handshake
  import roc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AER_WIDTH-1:0] aer_addr,
  input  logic                 aer_req,
  output logic                 aer_ack,
  output logic                 evt_valid,
  output logic [AER_WIDTH-1:0] evt_addr
);

  dec_state_e           state_q, state_d;
  logic                 ack_q, ack_d;
  logic [AER_WIDTH-1:0] addr_q, addr_d;
  logic                 req_s;

`ifdef ROC_DECODER_REQ_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // shift the raw request through two flops before the FSM sees it
  always_comb sync_d = {sync_q[0], aer_req};

  // synchroniser register
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign req_s = sync_q[1];
`else
  assign req_s = aer_req;
`endif

  // handshake state, acknowledge and latched address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
    end
  end

  // next-state logic; address is captured only on the request edge
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          addr_d  = aer_addr;
          ack_d   = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: state_d = WAIT_LO;
      WAIT_LO: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign aer_ack   = ack_q;
  assign evt_valid = (state_q == UPDATE);
  assign evt_addr  = addr_q;

endmodule

// File: rtl/roc_decoder.sv
// Rank-order-code AER decoder. Arms on a run of preamble codes, then assigns
// each new pixel index its arrival rank and tracks winner, count and errors.
// Build option: ROC_DECODER_REQ_SYNC_EN (see aer_rx_handshake) synchronises
// AER_REQ; undefined, the transmitter must run on CLK.
module roc_decoder
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [AER_WIDTH-1:0]       AER_ADDR,
  input  logic                       AER_REQ,
  output logic                       AER_ACK,
  input  logic                       STOP,
  input  logic [IMAGE_SIZE_BITS-1:0] RANK_RD_ADDR,
  output logic [IMAGE_SIZE_BITS-1:0] RANK_RD_DATA,
  output logic                       RANK_RD_VALID,
  output logic [IMAGE_SIZE_BITS-1:0] WINNER,
  output logic                       WINNER_VALID,
  output logic [IMAGE_SIZE_BITS:0]   EVENT_CNT,
  output logic                       ARMED,
  output logic                       DONE,
  output logic                       DUP_ERR,
  output logic                       ADDR_ERR
);

  localparam int                     RC_W     = $clog2(RESET_REPEAT + 1);
  localparam logic [RC_W-1:0]        RC_FULL  = RC_W'(RESET_REPEAT);
  localparam logic [RC_W-1:0]        RC_LAST  = RC_W'(RESET_REPEAT - 1);
  localparam logic [IMAGE_SIZE_BITS:0] CNT_FULL = (IMAGE_SIZE_BITS + 1)'(IMAGE_SIZE);

  logic                       evt_valid;
  logic [AER_WIDTH-1:0]       evt_addr;
  logic [IMAGE_SIZE_BITS-1:0] evt_idx;

  logic                       armed_q, armed_d;
  logic                       done_q, done_d;
  logic [IMAGE_SIZE_BITS-1:0] winner_q, winner_d;
  logic                       winner_vld_q, winner_vld_d;
  logic [IMAGE_SIZE_BITS:0]   cnt_q, cnt_d;
  logic                       dup_q, dup_d;
  logic                       aerr_q, aerr_d;
  logic [RC_W-1:0]            rcnt_q, rcnt_d;
  logic [IMAGE_SIZE-1:0]      valid_q, valid_d;
  logic [IMAGE_SIZE_BITS-1:0] rank_q [IMAGE_SIZE];
  logic                       rank_we;

  aer_rx_handshake u_hs (
    .clk       (CLK),
    .rst       (RST),
    .aer_addr  (AER_ADDR),
    .aer_req   (AER_REQ),
    .aer_ack   (AER_ACK),
    .evt_valid (evt_valid),
    .evt_addr  (evt_addr)
  );

  assign evt_idx = evt_addr[IMAGE_SIZE_BITS-1:0];

  // decoder status registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
      winner_q     <= '0;
      winner_vld_q <= 1'b0;
      cnt_q        <= '0;
      dup_q        <= 1'b0;
      aerr_q       <= 1'b0;
      rcnt_q       <= '0;
      valid_q      <= '0;
    end else begin
      armed_q      <= armed_d;
      done_q       <= done_d;
      winner_q     <= winner_d;
      winner_vld_q <= winner_vld_d;
      cnt_q        <= cnt_d;
      dup_q        <= dup_d;
      aerr_q       <= aerr_d;
      rcnt_q       <= rcnt_d;
      valid_q      <= valid_d;
    end
  end

  // rank storage; stale entries are masked by valid_q so no reset is needed
  always_ff @(posedge CLK) begin
    if (rank_we) rank_q[evt_idx] <= cnt_q[IMAGE_SIZE_BITS-1:0];
  end

  // event rules; preamble handling takes priority over everything else
  always_comb begin
    armed_d      = armed_q;
    done_d       = done_q | STOP | (cnt_q == CNT_FULL);
    winner_d     = winner_q;
    winner_vld_d = winner_vld_q;
    cnt_d        = cnt_q;
    dup_d        = dup_q;
    aerr_d       = aerr_q;
    rcnt_d       = rcnt_q;
    valid_d      = valid_q;
    rank_we      = 1'b0;
    if (evt_valid) begin
      if (evt_addr == RESET_CODE) begin
        if (rcnt_q != RC_FULL) rcnt_d = rcnt_q + 1'b1;
        // arm only on the code that completes the run, not on later repeats
        if (rcnt_q == RC_LAST) begin
          armed_d      = 1'b1;
          done_d       = 1'b0;
          valid_d      = '0;
          cnt_d        = '0;
          winner_vld_d = 1'b0;
          dup_d        = 1'b0;
          aerr_d       = 1'b0;
        end
      end else begin
        rcnt_d = '0;
        if (armed_q && !done_q) begin
          if (32'(evt_addr) >= IMAGE_SIZE) begin
            aerr_d = 1'b1;
          end else if (valid_q[evt_idx]) begin
            dup_d = 1'b1;
          end else begin
            rank_we          = 1'b1;
            valid_d[evt_idx] = 1'b1;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == '0) begin
              winner_d     = evt_idx;
              winner_vld_d = 1'b1;
            end
          end
        end
      end
    end
  end

  assign RANK_RD_VALID = valid_q[RANK_RD_ADDR];
  assign RANK_RD_DATA  = valid_q[RANK_RD_ADDR] ? rank_q[RANK_RD_ADDR] : '0;
  assign WINNER        = winner_q;
  assign WINNER_VALID  = winner_vld_q;
  assign EVENT_CNT     = cnt_q;
  assign ARMED         = armed_q;
  assign DONE          = done_q;
  assign DUP_ERR       = dup_q;
  assign ADDR_ERR      = aerr_q;

endmodule
